// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op codes seen on req_op, data width, and a small
// absolute-value helper used by the divider sign preparation.
package mdu_ctrl_pkg;

  localparam int MDU_OP_W = 3;
  localparam int DATA_W   = 32;

  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;

  // Two's complement magnitude; 0x8000_0000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset          clock / async active-high reset
//   start               load operands and begin (ignored result if unused)
//   dividend, divisor   unsigned operands, sampled on start
//   quotient, remainder result registers, final one cycle after done
//   done                high during the last iteration
module mdu_div_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  localparam int CNT_W = $clog2(W);

  logic [CNT_W-1:0] cnt;
  logic             running;
  logic [W-1:0]     divisor_q;
  logic [W:0]       shifted;
  logic [W:0]       diff;

  // quotient doubles as the shift register holding unconsumed dividend bits.
  always_comb begin
    shifted = {remainder, quotient[W-1]};
    diff    = shifted - {1'b0, divisor_q};
    done    = running && (cnt == CNT_W'(W - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      divisor_q <= '0;
      cnt       <= '0;
      running   <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      divisor_q <= divisor;
      cnt       <= '0;
      running   <= 1'b1;
    end else if (running) begin
      // A borrow (diff[W]) means the trial subtract failed: restore.
      remainder <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
      quotient  <= {quotient[W-2:0], ~diff[W]};
      cnt       <= cnt + CNT_W'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, runs multiplies and divides, and
// holds the execute stage through a completion handshake.
// Handshake: ES holds req_valid/op/operands until resp_done; an op is
// accepted when req_valid & req_ready; resp_done pulses for exactly one
// cycle per accepted op (same cycle for MTHI/MTLO and unknown ops).
// Ports:
//   clk, reset            clock / async active-high reset
//   req_valid, req_op     request and op code
//   req_src1, req_src2    rs / rt values
//   flush                 cancel in-flight op, no HI/LO update
//   req_ready, resp_done  handshake outputs
//   busy                  state != IDLE (ID interlock for MFHI/MFLO)
//   hi, lo                architectural HI/LO
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [MDU_OP_W-1:0] req_op,
  input  logic [DATA_W-1:0]   req_src1,
  input  logic [DATA_W-1:0]   req_src2,
  input  logic                flush,
  output logic                req_ready,
  output logic                resp_done,
  output logic                busy,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV_PREP, S_DIV_ITER, S_DIV_FIX, S_DONE
  } state_e;

  localparam int MUL_CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  state_e                 state, state_nxt;
  logic                   accept;
  logic [MDU_OP_W-1:0]    op_q;
  logic [DATA_W-1:0]      src1_q, src2_q;
  logic [MUL_CNT_W-1:0]   mul_cnt;
  logic                   sign_q, sign_r;
  logic [DATA_W-1:0]      res_hi, res_lo;
  logic                   div_signed, mul_signed, div_by_zero;
  logic [DATA_W-1:0]      div_a, div_b, div_quo, div_rem;
  logic                   div_start, div_done;
  logic [2*DATA_W-1:0]    mul_a, mul_b, mul_p;

  // Datapath decode on latched operands.
  always_comb begin
    div_signed  = (op_q == MDU_DIV);
    mul_signed  = (op_q == MDU_MULT);
    div_by_zero = (src2_q == '0);
    div_a       = div_signed ? abs_val(src1_q) : src1_q;
    div_b       = div_signed ? abs_val(src2_q) : src2_q;
    div_start   = (state == S_DIV_PREP) && !div_by_zero;
    // Sign-extending to 64 bits makes the low 64 bits of a plain multiply
    // correct for both signed and unsigned operands.
    mul_a       = {{DATA_W{mul_signed & src1_q[DATA_W-1]}}, src1_q};
    mul_b       = {{DATA_W{mul_signed & src2_q[DATA_W-1]}}, src2_q};
    mul_p       = mul_a * mul_b;
  end

  mdu_div_core #(.W(DIV_ITERS)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (div_a),
    .divisor   (div_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_op == MDU_MULT || req_op == MDU_MULTU)    state_nxt = S_MUL;
          else if (req_op == MDU_DIV || req_op == MDU_DIVU) state_nxt = S_DIV_PREP;
        end
      end
      S_MUL:      if (mul_cnt == MUL_CNT_W'(MUL_STAGES - 1)) state_nxt = S_DONE;
      S_DIV_PREP: state_nxt = div_by_zero ? S_DONE : S_DIV_ITER;
      S_DIV_ITER: if (div_done) state_nxt = S_DIV_FIX;
      S_DIV_FIX:  state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (flush && state != S_IDLE) state_nxt = S_IDLE;
  end

  // Handshake outputs. Ops other than MULT/MULTU/DIV/DIVU complete in the
  // accept cycle; unknown codes write nothing so ES is never left hanging.
  always_comb begin
    req_ready = (state == S_IDLE) && !flush;
    accept    = req_valid && req_ready;
    busy      = (state != S_IDLE);
    resp_done = ((state == S_DONE) && !flush) ||
                (accept && !(req_op == MDU_MULT || req_op == MDU_MULTU ||
                             req_op == MDU_DIV  || req_op == MDU_DIVU));
  end

  // Operand latch, result staging and HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      mul_cnt <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      res_hi  <= '0;
      res_lo  <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        src1_q  <= req_src1;
        src2_q  <= req_src2;
        mul_cnt <= '0;
        if (req_op == MDU_MTHI) hi <= req_src1;
        if (req_op == MDU_MTLO) lo <= req_src1;
      end
      case (state)
        S_MUL: begin
          mul_cnt          <= mul_cnt + MUL_CNT_W'(1);
          {res_hi, res_lo} <= mul_p;
        end
        S_DIV_PREP: begin
          sign_q <= div_signed & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]);
          sign_r <= div_signed & src1_q[DATA_W-1];
          if (div_by_zero) begin
            res_lo <= '1;
            res_hi <= src1_q;
          end
        end
        S_DIV_FIX: begin
          res_lo <= sign_q ? (~div_quo + DATA_W'(1)) : div_quo;
          res_hi <= sign_r ? (~div_rem + DATA_W'(1)) : div_rem;
        end
        S_DONE: begin
          if (!flush) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        req_ready, resp_done, busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .flush     (flush),
    .req_ready (req_ready),
    .resp_done (resp_done),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    exp_q.push_back(exp);
    n_cmp++;
    if (act !== exp_q.pop_front()) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[14];

  // ---------------- driver ----------------
  // Presents an op, measures cycles from accept to resp_done, then checks
  // busy during the op and HI/LO plus idle state the cycle after.
  task automatic run_op(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] eh, input logic [31:0] el, input int elat,
                        input string nm);
    int lat;
    bit seen;
    bit busy_bad;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2;
    #1;
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
    lat = 0; busy_bad = 0;
    seen = resp_done;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!busy) busy_bad = 1;
      if (resp_done) seen = 1;
    end
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " busy_during"}, 32'(busy_bad), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    chk({nm, " busy_after"}, 32'(busy), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    bit done_seen;
    vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 3,  "mult_m3x7"};
    vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3,  "multu_max"};
    vecs[2]  = '{MDU_MULT,  32'h7FFF_FFFF, 32'd2,        32'h0000_0000, 32'hFFFF_FFFE, 3,  "mult_maxpos"};
    vecs[3]  = '{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 3,  "mult_m1xm1"};
    vecs[4]  = '{MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        35, "divu_100_7"};
    vecs[5]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, "div_m7_2"};
    vecs[6]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 35, "div_min_m1"};
    vecs[7]  = '{MDU_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 2,  "div_5_0"};
    vecs[8]  = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  "divu_max_0"};
    vecs[9]  = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd10,       32'd5,         32'h1999_9999, 35, "divu_max_10"};
    vecs[10] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 35, "div_7_m2"};
    vecs[11] = '{MDU_MTHI,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFD, 0,  "mthi"};
    vecs[12] = '{MDU_MTLO,  32'h0000_0055, 32'd0,        32'h1234_5678, 32'h0000_0055, 0,  "mtlo_then_mflo"};
    vecs[13] = '{MDU_MULTU, 32'd2,         32'd3,        32'd0,         32'd6,         3,  "multu_2x3"};

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_done", 32'(resp_done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].hi, vecs[i].lo, vecs[i].lat, vecs[i].name);

    // Flush mid-divide: HI/LO preloaded, no completion, then a fresh multiply.
    run_op(MDU_MTHI, 32'hA, 32'd0, 32'hA, 32'd6, 0, "pre_mthi");
    run_op(MDU_MTLO, 32'hB, 32'd0, 32'hA, 32'hB, 0, "pre_mtlo");
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_DIVU; req_src1 = 32'd100; req_src2 = 32'd7;
    done_seen = 0;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_done) done_seen = 1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_div busy", 32'(busy), 32'd0);
    chk("flush_div ready", 32'(req_ready), 32'd1);
    chk("flush_div hi", hi, 32'hA);
    chk("flush_div lo", lo, 32'hB);
    repeat (40) begin
      @(negedge clk);
      if (resp_done) done_seen = 1;
    end
    chk("flush_div no_done", 32'(done_seen), 32'd0);
    run_op(MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 3, "post_flush_multu");

    // Flush landing on DONE: pulse suppressed and write dropped.
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_MULT; req_src1 = 32'hFFFF_FFFD; req_src2 = 32'd7;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("flush_done pre_done", 32'(resp_done), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_done resp_done", 32'(resp_done), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_done hi", hi, 32'd0);
    chk("flush_done lo", lo, 32'd6);
    chk("flush_done busy", 32'(busy), 32'd0);

    // Flush in IDLE blocks an MTHI.
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_MTHI; req_src1 = 32'h77; flush = 1'b1;
    #1;
    chk("flush_idle ready", 32'(req_ready), 32'd0);
    chk("flush_idle resp_done", 32'(resp_done), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle hi", hi, 32'd0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_DIVU; req_src1 = 32'd100; req_src2 = 32'd7;
    @(posedge clk);
    repeat (5) @(negedge clk);
    chk("rst_mid busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid ready", 32'(req_ready), 32'd1);
    chk("rst_mid hi", hi, 32'd0);
    chk("rst_mid lo", lo, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
